// File: rtl/param_data_cache_if.sv
// Bus bundle between the MIPS memory stage, the data cache and the
// main-memory model.
//   CPU side : cpu_addr, cpu_wdata, cpu_read, cpu_write  (requester -> cache)
//              cpu_rdata, cpu_stall                      (cache -> requester)
//   Mem side : mem_addr, mem_wdata, mem_read, mem_write  (cache -> memory)
//              mem_rdata, mem_ready                      (memory -> cache)
// Modport slave is the cache's view; modport master is the environment's view.
interface param_data_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/param_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache, one word per line.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : param_data_cache_if.slave (CPU request side + memory side)
//   hit_count  : saturating count of first-cycle hits
//   miss_count : saturating count of misses
// Hits complete combinationally with no stall. A miss optionally writes the
// dirty victim back, fills the line, then replays the held request as a hit.
module param_data_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LINES   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  param_data_cache_if.slave      bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q [NUM_LINES];
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]    valid_q, dirty_q;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [COUNT_WIDTH-1:0]  hit_q, miss_q;
  // Set for the one cycle after a fill, so the replayed access is not
  // counted as a hit.
  logic                    replay_q;

  logic [IDX-1:0]   index;
  logic [TAG_W-1:0] tag;
  logic             req, hit, victim_dirty;
  logic             fill, wr_hit, miss_start, count_hit;
  logic             unused_addr_bits;

  assign index            = bus.cpu_addr[IDX+1:2];
  assign tag              = bus.cpu_addr[ADDR_WIDTH-1:IDX+2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign req              = bus.cpu_read | bus.cpu_write;
  assign hit              = req & valid_q[index] & (tag_q[index] == tag);
  assign victim_dirty     = valid_q[index] & dirty_q[index];

  assign bus.cpu_stall = (state_q != IDLE) | (req & ~hit);
  assign bus.cpu_rdata = (state_q == IDLE && hit && bus.cpu_read) ? data_q[index]
                                                                  : '0;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  // Next state plus next values of the registered memory strobes/bus.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill        = 1'b0;
    wr_hit      = 1'b0;
    miss_start  = 1'b0;
    count_hit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          wr_hit    = bus.cpu_write;
          count_hit = ~replay_q;
        end else if (req) begin
          miss_start = 1'b1;
          if (victim_dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[index], index, 2'b00};
            mem_wdata_d = data_q[index];
          end else begin
            state_d    = ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = {tag, index, 2'b00};
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready) begin
          state_d    = ALLOCATE;
          mem_read_d = 1'b1;
          mem_addr_d = {tag, index, 2'b00};
        end else begin
          mem_write_d = 1'b1;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      replay_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      replay_q    <= fill;
      if (fill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[index] <= 1'b1;
      end
      if (count_hit)  hit_q  <= sat_inc(hit_q);
      if (miss_start) miss_q <= sat_inc(miss_q);
    end
  end

  // Line storage is only meaningful behind a set valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[index] <= bus.mem_rdata;
      tag_q[index]  <= tag;
    end else if (wr_hit) begin
      data_q[index] <= bus.cpu_wdata;
    end
  end
endmodule
